md_issue: RTL and testbench
===========================

MD_ISSUE -- requirements
Module: md_issue

Interface
REQ-001 Parameter MULT_LAT, default 5, SHALL set the busy cycles for mult/multu (legal range 1..15).
REQ-002 Parameter DIV_LAT, default 10, SHALL set the busy cycles for div/divu (legal range 1..15).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  an E-stage multiply/divide-class instruction is present.
REQ-006 req_op  in  4  operation: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; any other value is a non-md op.
REQ-007 req_a  in  32  rs operand.
REQ-008 req_b  in  32  rt operand.
REQ-009 md_hi  in  32  HI register value from the multiply/divide unit.
REQ-010 md_lo  in  32  LO register value from the multiply/divide unit.
REQ-011 stall  out  1  combinational; holds the request and freezes the pipeline front.
REQ-012 md_start  out  1  registered one-cycle issue strobe to the multiply/divide unit.
REQ-013 md_op  out  4  registered; req_op of the issued operation.
REQ-014 md_d1  out  32  registered; req_a of the issued operation.
REQ-015 md_d2  out  32  registered; req_b of the issued operation.
REQ-016 rd_valid  out  1  registered; mfhi/mflo result is valid.
REQ-017 rd_data  out  32  registered; mfhi/mflo result.

Function
REQ-018 State machine: IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-019 Acceptance: a request in cycle N with req_valid=1, legal op (1..8) and stall=0 SHALL be accepted at the end of cycle N.
REQ-020 Accepted op 1..6: md_start=1 with md_op/md_d1/md_d2 = req_op/req_a/req_b during cycle N+1 only; md_start=0 in all other cycles.
REQ-021 Accepted op 1/2: state goes to BUSY and cnt loads MULT_LAT.
REQ-022 Accepted op 3/4: state goes to BUSY and cnt loads DIV_LAT.
REQ-023 Accepted op 5/6: state stays IDLE; the op is single-cycle with no busy period.
REQ-024 BUSY: cnt decrements every edge; on the edge where cnt goes 1->0, state returns to IDLE.
REQ-025 BUSY therefore spans exactly cycles N+1..N+LAT.
REQ-026 stall = req_valid & (req_op in 1..8) & (state==BUSY).
REQ-027 A request arriving in the final BUSY cycle SHALL be stalled and accepted in the following cycle.
REQ-028 Accepted op 7/8: rd_valid=1 during cycle N+1, with rd_data = md_hi (op 7) or md_lo (op 8) as sampled at the cycle-N edge.
REQ-029 rd_valid=0 in every other cycle; rd_data holds its last value.
REQ-030 Non-md op (req_op 0 or 9..15) or req_valid=0: no issue, no rd_valid, stall=0, state unaffected.
REQ-031 Divide by zero SHALL be issued normally and still occupy DIV_LAT cycles.
REQ-032 A stalled request SHALL cause no output change.
REQ-033 Issue outputs SHALL hold their values while md_start=0.

Reset
REQ-034 reset=0 SHALL immediately force state=IDLE, cnt=0, md_start=0, md_op=0, md_d1=0, md_d2=0, rd_valid=0 and rd_data=0.
REQ-035 stall SHALL fall to 0 immediately on reset, including when reset is asserted mid-BUSY.
REQ-036 The first edge after reset rises SHALL accept requests normally.

Verification
REQ-037 Reset held low with random inputs -> every output 0 and stall=0 throughout.
REQ-038 mult a=0xFFFFFFFA b=0xFFFFFFFD at cycle 0 -> cycle 1: md_start=1, md_op=1, md_d1=0xFFFFFFFA, md_d2=0xFFFFFFFD; mfhi held from cycle 1 stalls cycles 1-5, is accepted at cycle 6, and gives rd_valid=1 at cycle 7 with rd_data=md_hi.
REQ-039 div at cycle 0 followed by divu at cycle 1 -> divu stalled cycles 1-10, accepted at cycle 11, md_start at cycle 12; no md_start in cycles 2-11.
REQ-040 mthi a=0x12345678 at cycle 0, mflo at cycle 1 -> md_start in cycle 1 only with md_op=5; mflo not stalled and gives rd_valid at cycle 2.
REQ-041 div issued, reset pulsed low mid-cycle 3 -> stall drops asynchronously; mult at the first edge after release is issued the next cycle with a full MULT_LAT busy period.
REQ-042 req_op=9 and req_op=0 with req_valid=1 in both IDLE and BUSY -> stall=0, no md_start, no rd_valid, cnt unaffected.

Source files
------------

// File: rtl/md_issue.sv
// Issue/interlock stage for the multiply/divide unit: launches mult/div/mthi/mtlo,
// returns mfhi/mflo results and stalls md-class requests while the unit is busy.
module md_issue #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [31:0] md_hi,
   input  logic [31:0] md_lo,
   output logic        stall,
   output logic        md_start,
   output logic [3:0]  md_op,
   output logic [31:0] md_d1,
   output logic [31:0] md_d2,
   output logic        rd_valid,
   output logic [31:0] rd_data
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        md_start_q, md_start_d;
   logic [3:0]  md_op_q, md_op_d;
   logic [31:0] md_d1_q, md_d1_d;
   logic [31:0] md_d2_q, md_d2_d;
   logic        rd_valid_q, rd_valid_d;
   logic [31:0] rd_data_q, rd_data_d;

   logic op_legal;
   logic op_mul;
   logic op_div;
   logic op_issue;
   logic op_read;
   logic accept;

   always_comb begin
      op_legal = (req_op >= OP_MULT) && (req_op <= OP_MFLO);
      op_mul   = (req_op == OP_MULT) || (req_op == OP_MULTU);
      op_div   = (req_op == OP_DIV)  || (req_op == OP_DIVU);
      op_issue = op_mul || op_div || (req_op == OP_MTHI) || (req_op == OP_MTLO);
      op_read  = (req_op == OP_MFHI) || (req_op == OP_MFLO);
   end

   // Stall follows state_q directly, so an asynchronous reset drops it at once.
   assign stall  = req_valid & op_legal & (state_q == BUSY);
   assign accept = req_valid & op_legal & (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept && op_mul) begin
               state_d = BUSY;
               cnt_d   = MULT_CNT;
            end else if (accept && op_div) begin
               state_d = BUSY;
               cnt_d   = DIV_CNT;
            end
         end
         BUSY: begin
            if (cnt_q <= 4'd1) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      md_start_d = accept & op_issue;
      md_op_d    = md_op_q;
      md_d1_d    = md_d1_q;
      md_d2_d    = md_d2_q;
      rd_valid_d = accept & op_read;
      rd_data_d  = rd_data_q;
      if (md_start_d) begin
         md_op_d = req_op;
         md_d1_d = req_a;
         md_d2_d = req_b;
      end
      if (rd_valid_d) begin
         rd_data_d = (req_op == OP_MFHI) ? md_hi : md_lo;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         md_start_q <= 1'b0;
         md_op_q    <= 4'd0;
         md_d1_q    <= 32'd0;
         md_d2_q    <= 32'd0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         md_start_q <= md_start_d;
         md_op_q    <= md_op_d;
         md_d1_q    <= md_d1_d;
         md_d2_q    <= md_d2_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign md_start = md_start_q;
   assign md_op    = md_op_q;
   assign md_d1    = md_d1_q;
   assign md_d2    = md_d2_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_md_issue.sv
// Scoreboard bench for md_issue: a cycle-indexed reference model predicts stall,
// issue strobes and mfhi/mflo results; a negedge monitor compares the DUT against it.
module tb_md_issue;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [31:0] md_hi;
   logic [31:0] md_lo;
   logic        stall;
   logic        md_start;
   logic [3:0]  md_op;
   logic [31:0] md_d1;
   logic [31:0] md_d2;
   logic        rd_valid;
   logic [31:0] rd_data;

   md_issue #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .md_hi     (md_hi),
      .md_lo     (md_lo),
      .stall     (stall),
      .md_start  (md_start),
      .md_op     (md_op),
      .md_d1     (md_d1),
      .md_d2     (md_d2),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data)
   );

   typedef struct {
      int          cyc;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } issue_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } rd_t;

   issue_t issue_q[$];
   rd_t    rd_q[$];

   int n_compared   = 0;
   int n_mismatched = 0;
   int cyc          = 0;
   int busy_until   = -1;
   logic last_stall = 1'b0;

   logic [3:0]  hold_op   = 4'd0;
   logic [31:0] hold_d1   = 32'd0;
   logic [31:0] hold_d2   = 32'd0;
   logic [31:0] hold_rd   = 32'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
                  name, cyc, actual, expected);
      end
   endtask

   // Reference model: an accepted mult/div keeps the unit busy through cycle N+LAT.
   task automatic modelStep();
      logic legal;
      logic busy;
      logic exp_stall;
      legal     = (req_op >= 4'd1) && (req_op <= 4'd8);
      busy      = (cyc <= busy_until);
      exp_stall = reset && req_valid && legal && busy;
      checkOutput("stall", {31'd0, stall}, {31'd0, exp_stall});
      last_stall = exp_stall;
      if (reset && req_valid && legal && !busy) begin
         if (req_op <= 4'd6) issue_q.push_back('{cyc + 1, req_op, req_a, req_b});
         if (req_op == 4'd7) rd_q.push_back('{cyc + 1, md_hi});
         if (req_op == 4'd8) rd_q.push_back('{cyc + 1, md_lo});
         if (req_op == 4'd1 || req_op == 4'd2) busy_until = cyc + MULT_LAT;
         if (req_op == 4'd3 || req_op == 4'd4) busy_until = cyc + DIV_LAT;
      end
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
   task automatic applyStimulus(input logic v, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b);
      req_valid = v;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      md_hi     = $urandom;
      md_lo     = $urandom;
      #2;
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
   endtask

   always @(negedge clk) begin
      logic exp_start;
      logic exp_rd;
      issue_t ie;
      rd_t    re;
      if (!reset) begin
         checkOutput("reset_md_start", {31'd0, md_start}, 32'd0);
         checkOutput("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
         checkOutput("reset_stall", {31'd0, stall}, 32'd0);
         checkOutput("reset_md_op", {28'd0, md_op}, 32'd0);
         checkOutput("reset_md_d1", md_d1, 32'd0);
         checkOutput("reset_md_d2", md_d2, 32'd0);
         checkOutput("reset_rd_data", rd_data, 32'd0);
         issue_q.delete();
         rd_q.delete();
         hold_op = 4'd0;
         hold_d1 = 32'd0;
         hold_d2 = 32'd0;
         hold_rd = 32'd0;
      end else begin
         exp_start = (issue_q.size() > 0) && (issue_q[0].cyc == cyc);
         checkOutput("md_start", {31'd0, md_start}, {31'd0, exp_start});
         if (exp_start) begin
            ie = issue_q.pop_front();
            hold_op = ie.op;
            hold_d1 = ie.a;
            hold_d2 = ie.b;
         end
         checkOutput("md_op", {28'd0, md_op}, {28'd0, hold_op});
         checkOutput("md_d1", md_d1, hold_d1);
         checkOutput("md_d2", md_d2, hold_d2);
         exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
         checkOutput("rd_valid", {31'd0, rd_valid}, {31'd0, exp_rd});
         if (exp_rd) begin
            re = rd_q.pop_front();
            hold_rd = re.data;
         end
         checkOutput("rd_data", rd_data, hold_rd);
      end
   end

   initial begin
      logic [3:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;
      logic        r_v;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_op    = 4'd0;
      req_a     = 32'd0;
      req_b     = 32'd0;
      md_hi     = 32'd0;
      md_lo     = 32'd0;
      @(posedge clk);
      #1;

      $display("[TB] reset held low with random inputs");
      for (int i = 0; i < 8; i++)
         applyStimulus($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom, $urandom);

      $display("[TB] mult then held mfhi");
      reset = 1'b1;
      applyStimulus(1'b1, 4'd1, 32'hFFFF_FFFA, 32'hFFFF_FFFD);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'd7, 32'd0, 32'd0);
      idleCycles(2);

      $display("[TB] div then held divu");
      applyStimulus(1'b1, 4'd3, 32'd100, 32'd0);
      for (int i = 0; i < 11; i++) applyStimulus(1'b1, 4'd4, 32'd77, 32'd7);
      idleCycles(12);

      $display("[TB] mthi then mflo");
      applyStimulus(1'b1, 4'd5, 32'h1234_5678, 32'd0);
      applyStimulus(1'b1, 4'd8, 32'd0, 32'd0);
      idleCycles(2);

      $display("[TB] non-md ops in idle and busy");
      applyStimulus(1'b1, 4'd9, 32'd1, 32'd2);
      applyStimulus(1'b1, 4'd0, 32'd3, 32'd4);
      applyStimulus(1'b1, 4'd2, 32'd5, 32'd6);
      applyStimulus(1'b1, 4'd9, 32'd7, 32'd8);
      applyStimulus(1'b1, 4'd0, 32'd9, 32'd10);
      applyStimulus(1'b1, 4'd15, 32'd11, 32'd12);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd8, 32'd0, 32'd0);
      idleCycles(2);

      $display("[TB] reset pulse during a divide");
      applyStimulus(1'b1, 4'd3, 32'd50, 32'd5);
      idleCycles(2);
      req_valid = 1'b1;
      req_op    = 4'd1;
      req_a     = 32'hDEAD_BEEF;
      req_b     = 32'h0000_0003;
      #1;
      checkOutput("stall_busy_before_reset", {31'd0, stall}, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("stall_async_reset", {31'd0, stall}, 32'd0);
      #3;
      reset = 1'b1;
      #1;
      busy_until = -1;
      modelStep();
      @(posedge clk);
      #1;
      for (int i = 0; i < MULT_LAT + 1; i++) applyStimulus(1'b1, 4'd7, 32'd0, 32'd0);
      idleCycles(2);

      $display("[TB] randomized traffic");
      r_v  = 1'b0;
      r_op = 4'd0;
      r_a  = 32'd0;
      r_b  = 32'd0;
      for (int i = 0; i < 500; i++) begin
         if (!(last_stall && ($urandom_range(0, 9) < 7))) begin
            r_v  = ($urandom_range(0, 1) == 1);
            r_op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'($urandom_range(1, 8));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         end
         applyStimulus(r_v, r_op, r_a, r_b);
      end
      idleCycles(20);

      checkOutput("scoreboard_drained", 32'(issue_q.size() + rd_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
